store_issue_unit: RTL

Front end of the store path: accepts one store instruction per request from issue, checks alignment, and requests address translation from the MMU. It generates the byte enables and lane-aligned write data, then pushes the store into the speculative store buffer and reports completion or exceptions back to the scoreboard. It sits directly upstream of the store buffer and drives its valid/paddr/data/be/size inputs.

---
 rtl/store_issue_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/store_issue_unit.sv
// Store issue front end: takes one store from issue, checks alignment,
// requests address translation, aligns data/byte enables to the 8-byte lane
// and pushes the store into the speculative store buffer. Completion or
// exception status is reported back to the scoreboard one cycle after the
// store resolves.
module store_issue_unit #(
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [63:0]              vaddr_i,
    input  logic [63:0]              data_i,
    input  logic [1:0]               size_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     translation_req_o,
    output logic [63:0]              vaddr_o,
    input  logic                     translation_valid_i,
    input  logic [63:0]              paddr_i,
    input  logic                     page_fault_i,
    input  logic                     sb_ready_i,
    output logic                     sb_valid_o,
    output logic                     sb_valid_without_flush_o,
    output logic [63:0]              sb_paddr_o,
    output logic [63:0]              sb_data_o,
    output logic [7:0]               sb_be_o,
    output logic [1:0]               sb_size_o,
    output logic                     result_valid_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
    output logic                     misaligned_o,
    output logic                     page_fault_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRANS,
        WAIT_SB
    } state_e;

    state_e                   state_q;
    logic [63:0]              vaddr_q;
    logic [63:0]              paddr_q;
    logic [63:0]              data_q;
    logic [7:0]               be_q;
    logic [1:0]               size_q;
    logic [TRANS_ID_BITS-1:0] trans_id_q;
    logic                     result_valid_q;
    logic                     misaligned_q;
    logic                     page_fault_q;

    logic                     accept;
    logic                     misaligned;
    logic [7:0]               be_base;
    logic [7:0]               be_next;
    logic [63:0]              data_next;

    // Handshake and qualifier outputs are held low for the whole reset cycle,
    // even though the state register only clears on the reset edge.
    assign ready_o                  = (state_q == IDLE) && !flush_i && !rst_i;
    assign accept                   = valid_i && ready_o;
    assign translation_req_o        = (state_q == WAIT_TRANS) && !rst_i;
    assign sb_valid_without_flush_o = (state_q == WAIT_SB) && !rst_i;
    assign sb_valid_o               = (state_q == WAIT_SB) && sb_ready_i && !flush_i && !rst_i;

    assign vaddr_o           = vaddr_q;
    assign sb_paddr_o        = paddr_q;
    assign sb_data_o         = data_q;
    assign sb_be_o           = be_q;
    assign sb_size_o         = size_q;
    assign result_valid_o    = result_valid_q;
    assign result_trans_id_o = trans_id_q;
    assign misaligned_o      = misaligned_q;
    assign page_fault_o      = page_fault_q;

    // Alignment check, byte-enable and lane-aligned data for the incoming request.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        misaligned = 1'b0;
        be_base    = 8'h01;
        unique case (size_i)
            2'd0: begin
                be_base    = 8'h01;
                misaligned = 1'b0;
            end
            2'd1: begin
                be_base    = 8'h03;
                misaligned = vaddr_i[0];
            end
            2'd2: begin
                be_base    = 8'h0F;
                misaligned = |vaddr_i[1:0];
            end
            default: begin
                be_base    = 8'hFF;
                misaligned = |vaddr_i[2:0];
            end
        endcase
        be_next   = be_base << vaddr_i[2:0];
        data_next = data_i << {vaddr_i[2:0], 3'b000};
    end

    // Store sequencing FSM with registered request fields and result pulse.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q        <= IDLE;
            vaddr_q        <= '0;
            paddr_q        <= '0;
            data_q         <= '0;
            be_q           <= '0;
            size_q         <= '0;
            trans_id_q     <= '0;
            result_valid_q <= 1'b0;
            misaligned_q   <= 1'b0;
            page_fault_q   <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            misaligned_q   <= 1'b0;
            page_fault_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        vaddr_q    <= vaddr_i;
                        data_q     <= data_next;
                        be_q       <= be_next;
                        size_q     <= size_i;
                        trans_id_q <= trans_id_i;
                        if (misaligned) begin
                            result_valid_q <= 1'b1;
                            misaligned_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT_TRANS;
                        end
                    end
                end
                WAIT_TRANS: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (translation_valid_i) begin
                        if (page_fault_i) begin
                            result_valid_q <= 1'b1;
                            page_fault_q   <= 1'b1;
                            state_q        <= IDLE;
                        end else begin
                            paddr_q <= paddr_i;
                            state_q <= WAIT_SB;
                        end
                    end
                end
                WAIT_SB: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (sb_ready_i) begin
                        result_valid_q <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
